dm_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single-port 19-bit data memory (1024 words).

---
 rtl/dm_port_arbiter.sv | 85 ++++++++
 tb/tb_dm_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-requester arbiter/sequencer for a single-port data memory
module dm_port_arbiter #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 10,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              dm_wr_en,
  output logic              dm_rd_en,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, own_q, own_d, last_q, last_d, pick1, grant;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  always_comb begin
    pick1 = m1_req & (!m0_req | (!FIXED_PRIO & !last_q));
    grant = rst_n & (state_q == IDLE) & (m0_req | m1_req);
    state_d = state_q;
    we_d = we_q;
    own_d = own_q;
    last_d = last_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ISSUE;
        own_d = pick1;
        last_d = pick1;
        we_d = pick1 ? m1_we : m0_we;
        addr_d = pick1 ? m1_addr : m0_addr;
        wdata_d = pick1 ? m1_wdata : m0_wdata;
      end
      ISSUE: state_d = we_q ? IDLE : RDWAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      own_q <= 1'b0;
      last_q <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      own_q <= own_d;
      last_q <= last_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign m0_gnt = grant & !pick1;
  assign m1_gnt = grant & pick1;
  assign dm_wr_en = (state_q == ISSUE) & we_q;
  assign dm_rd_en = (state_q == ISSUE) & !we_q;
  assign dm_addr = addr_q;
  assign dm_wdata = wdata_q;
  assign busy = state_q != IDLE;
  assign m0_rvalid = rst_n & (state_q == RDWAIT) & !own_q;
  assign m1_rvalid = rst_n & (state_q == RDWAIT) & own_q;
  assign m0_rdata = dm_rdata;
  assign m1_rdata = dm_rdata;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: scoreboard bench running round-robin (u[0]) and fixed-priority (u[1]) instances
module tb_dm_port_arbiter;
  logic clk = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic id;
    logic we;
    logic [9:0] addr;
    logic [18:0] data;
    int due;
  } txn_t;
  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    logic rst_n;
    logic [1:0] req, we, gnt, rv, gs;
    logic [9:0] addr [2];
    logic [18:0] wd [2], rd [2];
    logic dm_wr_en, dm_rd_en, busy;
    logic [9:0] dm_addr;
    logic [18:0] dm_wdata, dm_rdata;
    logic [18:0] mem [1024];
    logic [18:0] ref_mem [1024];
    bit done = 1'b0;
    bit was_rst = 1'b0;
    logic last = 1'b1;
    int left = 0;
    int cyc = 0;
    txn_t txq[$], rdq[$];
    dm_port_arbiter #(.DATA_W(19), .ADDR_W(10), .FIXED_PRIO(g == 1)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wd[0]),
      .m0_gnt(gnt[0]), .m0_rvalid(rv[0]), .m0_rdata(rd[0]),
      .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wd[1]),
      .m1_gnt(gnt[1]), .m1_rvalid(rv[1]), .m1_rdata(rd[1]),
      .dm_wr_en(dm_wr_en), .dm_rd_en(dm_rd_en), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .busy(busy)
    );
    // Memory with registered read port
    always @(posedge clk) begin
      if (dm_wr_en) mem[dm_addr] <= dm_wdata;
      if (dm_rd_en) dm_rdata <= mem[dm_addr];
    end
    // Reference model: a grant is due whenever the model has no transaction in flight
    always @(negedge clk) begin
      logic win;
      logic [1:0] eg;
      logic [18:0] wm;
      txn_t t;
      cyc++;
      if (!rst_n) begin
        chk(gnt == 0 && rv == 0, "rst_gnt_rvalid", 64'({gnt, rv}), 64'(0));
        if (was_rst)
          chk({busy, dm_wr_en, dm_rd_en} == 0 && dm_addr == 0 && dm_wdata == 0, "rst_outputs",
              64'({busy, dm_wr_en, dm_rd_en, dm_addr, dm_wdata}), 64'(0));
        was_rst = 1'b1;
        left = 0;
        last = 1'b1;
        txq.delete();
        rdq.delete();
      end else begin
        was_rst = 1'b0;
        eg = 2'b00;
        chk(busy == (left != 0), "busy", 64'(busy), 64'(left != 0));
        if (left != 0) left--;
        else if (req != 0) begin
          win = (req == 2'b11) ? ((g == 1) ? 1'b0 : ~last) : req[1];
          eg[win] = 1'b1;
          last = win;
          t = '{win, we[win], addr[win], wd[win], cyc + 1};
          txq.push_back(t);
          if (we[win]) begin
            ref_mem[addr[win]] = wd[win];
            left = 1;
          end else begin
            t.data = ref_mem[addr[win]];
            t.due = cyc + 2;
            rdq.push_back(t);
            left = 2;
          end
        end
        chk(gnt == eg, "gnt", 64'(gnt), 64'(eg));
        if (dm_wr_en || dm_rd_en) begin
          if (txq.size() == 0) chk(1'b0, "dm_spurious", 64'({dm_wr_en, dm_rd_en}), 64'(0));
          else begin
            t = txq.pop_front();
            wm = {19{t.we}};
            chk(cyc == t.due, "dm_latency", 64'(cyc), 64'(t.due));
            chk({dm_wr_en, dm_rd_en, dm_addr, dm_wdata & wm} == {t.we, ~t.we, t.addr, t.data & wm}, "dm_access",
                64'({dm_wr_en, dm_rd_en, dm_addr, dm_wdata & wm}), 64'({t.we, ~t.we, t.addr, t.data & wm}));
          end
        end else if (txq.size() != 0 && txq[0].due < cyc) begin
          chk(1'b0, "dm_missing", 64'(0), 64'(1));
          txq.delete(0);
        end
        if (rv != 0) begin
          if (rdq.size() == 0) chk(1'b0, "rvalid_spurious", 64'(rv), 64'(0));
          else begin
            t = rdq.pop_front();
            chk(cyc == t.due, "rvalid_latency", 64'(cyc), 64'(t.due));
            chk({rv, rd[t.id]} == {(t.id ? 2'b10 : 2'b01), t.data}, "rdata",
                64'({rv, rd[t.id]}), 64'({(t.id ? 2'b10 : 2'b01), t.data}));
          end
        end else if (rdq.size() != 0 && rdq[0].due < cyc) begin
          chk(1'b0, "rvalid_missing", 64'(0), 64'(1));
          rdq.delete(0);
        end
      end
    end
    task automatic step();
      @(negedge clk);
      gs = gnt;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) if (gs[k]) req[k] = 1'b0;
    endtask
    task automatic go(input int k, input logic w, input logic [9:0] a, input logic [18:0] d);
      req[k] = 1'b1;
      we[k] = w;
      addr[k] = a;
      wd[k] = d;
    endtask
    task automatic settle();
      int n = 0;
      while ((req != 0 || busy) && n < 60) begin
        step();
        n++;
      end
      if (n >= 60) chk(1'b0, "settle_timeout", 64'(n), 64'(0));
    endtask
    task automatic wait_gnt(input int k);
      int n = 0;
      do begin
        step();
        n++;
      end while (!gs[k] && n < 30);
      if (!gs[k]) chk(1'b0, "gnt_timeout", 64'(n), 64'(0));
    endtask
    initial begin
      int c0, c1;
      rst_n = 1'b0;
      req = 2'b11;
      we = 2'b00;
      for (int k = 0; k < 2; k++) begin
        addr[k] = '0;
        wd[k] = '0;
      end
      for (int i = 0; i < 1024; i++) begin
        mem[i] <= '0;
        ref_mem[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle();
      go(0, 1'b1, 10'h005, 19'h7FFFF);
      settle();
      go(1, 1'b0, 10'h005, 19'h0);
      settle();
      go(0, 1'b0, 10'h005, 19'h0);
      go(1, 1'b0, 10'h006, 19'h0);
      c0 = 0;
      c1 = 0;
      for (int n = 0; n < 100 && c0 + c1 < 8; n++) begin
        step();
        c0 += int'(gs[0]);
        c1 += int'(gs[1]);
        if (c0 + c1 < 8) begin
          if (gs[0]) req[0] = 1'b1;
          if (gs[1]) req[1] = 1'b1;
        end
      end
      chk(c0 == ((g == 1) ? 8 : 4), "conflict_m0_grants", 64'(c0), 64'((g == 1) ? 8 : 4));
      settle();
      go(1, 1'b1, 10'h3FF, 19'h12345);
      go(0, 1'b0, 10'h3FF, 19'h0);
      settle();
      go(0, 1'b0, 10'h3FF, 19'h0);
      settle();
      go(0, 1'b0, 10'h007, 19'h0);
      wait_gnt(0);
      step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      settle();
      go(1, 1'b0, 10'h009, 19'h0);
      wait_gnt(1);
      go(0, 1'b0, 10'h009, 19'h0);
      step();
      req[0] = 1'b0;
      settle();
      for (int n = 0; n < 300; n++) begin
        for (int k = 0; k < 2; k++) begin
          if (!req[k] && $urandom_range(2) == 0)
            go(k, 1'($urandom), $urandom_range(1) ? 10'($urandom_range(7)) : 10'($urandom), 19'($urandom));
          else if (req[k] && $urandom_range(11) == 0) req[k] = 1'b0;
        end
        step();
      end
      settle();
      repeat (3) step();
      done = 1'b1;
    end
  end
  initial begin
    wait (u[0].done && u[1].done);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
